// File: rtl/spi_globals_pkg.sv
// Shared types and helpers for the SPI slave shift engine.
// Lane-mode decode and frame FSM state encoding.
package spi_globals_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        DUAL   = 2'd1,
        QUAD   = 2'd2
    } lane_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } frame_state_e;

    function automatic int unsigned lanes_per_beat(lane_mode_e m);
        case (m)
            DUAL:    return 2;
            QUAD:    return 4;
            default: return 1;
        endcase
    endfunction

    // The reserved encoding 3 falls back to single-lane operation.
    function automatic lane_mode_e decode_lanes(logic [1:0] cfg);
        case (cfg)
            2'd1:    return DUAL;
            2'd2:    return QUAD;
            default: return SINGLE;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(lane_mode_e m);
        case (m)
            DUAL:    return 4'b0011;
            QUAD:    return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// generated on the synchronised value.
module spi_sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_shift_engine.sv
// SPI slave datapath: oversampled sclk/cs/mosi, all four CPOL/CPHA modes,
// 1/2/4 lanes, MSB/LSB-first, valid/ready word exchange with the SoC side.
module spi_slave_shift_engine
    import spi_globals_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '1,
    parameter int                    SYNC_STAGES  = 2
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_lsb_first,
    input  logic [1:0]            cfg_lanes,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic [3:0]            mosi,
    output logic [3:0]            miso,
    output logic [3:0]            miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  frame_abort
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;

    spi_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (pclk),
        .rst_n (areset),
        .d     (sclk),
        .q     (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs resets to the inactive level so reset release never fakes a frame start.
    spi_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (pclk),
        .rst_n (areset),
        .d     (cs),
        .q     (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic [SYNC_STAGES-1:0][3:0] mosi_sync_q, mosi_sync_d;
    logic [3:0]                  mosi_s;

    always_comb begin
        mosi_sync_d[0] = mosi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_sync_d[i] = mosi_sync_q[i-1];
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) mosi_sync_q <= '0;
        else         mosi_sync_q <= mosi_sync_d;
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // An sclk edge is leading when it moves the clock away from its idle level.
    logic sclk_edge, lead, trail;
    assign sclk_edge = sclk_rise | sclk_fall;
    assign lead      = sclk_edge & (sclk_s != cfg_cpol);
    assign trail     = sclk_edge & (sclk_s == cfg_cpol);

    lane_mode_e       mode;
    logic [CNT_W-1:0] beats_n;
    assign mode    = decode_lanes(cfg_lanes);
    assign beats_n = CNT_W'(DATA_WIDTH / lanes_per_beat(mode));

    function automatic logic [3:0] beat_out(word_t w, lane_mode_e m, logic lsb);
        logic [3:0] b;
        b = '0;
        case (m)
            QUAD:    b      = lsb ? w[3:0] : w[DATA_WIDTH-1 -: 4];
            DUAL:    b[1:0] = lsb ? w[1:0] : w[DATA_WIDTH-1 -: 2];
            default: b[0]   = lsb ? w[0]   : w[DATA_WIDTH-1];
        endcase
        return b;
    endfunction

    function automatic word_t shift_out(word_t w, lane_mode_e m, logic lsb);
        case (m)
            QUAD:    return lsb ? (w >> 4) : (w << 4);
            DUAL:    return lsb ? (w >> 2) : (w << 2);
            default: return lsb ? (w >> 1) : (w << 1);
        endcase
    endfunction

    function automatic word_t shift_in(word_t sr, logic [3:0] bits, lane_mode_e m, logic lsb);
        case (m)
            QUAD:    return lsb ? {bits[3:0], sr[DATA_WIDTH-1:4]} : {sr[DATA_WIDTH-5:0], bits[3:0]};
            DUAL:    return lsb ? {bits[1:0], sr[DATA_WIDTH-1:2]} : {sr[DATA_WIDTH-3:0], bits[1:0]};
            default: return lsb ? {bits[0],   sr[DATA_WIDTH-1:1]} : {sr[DATA_WIDTH-2:0], bits[0]};
        endcase
    endfunction

    frame_state_e     state_q, state_d;
    word_t            tx_sr_q, tx_sr_d;
    word_t            rx_sr_q, rx_sr_d;
    word_t            rx_data_q, rx_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       miso_q, miso_d;
    logic [3:0]       oe_q, oe_d;
    logic             rx_valid_q, rx_valid_d;
    logic             abort_q, abort_d;
    logic             started_q, started_d;
    word_t            load_word;
    logic             do_shift, do_sample;

    assign load_word = tx_valid ? tx_data : IDLE_PATTERN;
    assign cnt_inc   = cnt_q + 1'b1;
    assign do_shift  = cfg_cpha ? lead  : trail;
    assign do_sample = cfg_cpha ? trail : lead;

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        started_d  = started_q;
        rx_valid_d = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    oe_d   = '0;
                    miso_d = '0;
                end
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                oe_d      = lane_mask(mode);
                cnt_d     = '0;
                started_d = 1'b0;
                rx_sr_d   = '0;
                if (!cfg_cpha) begin
                    miso_d  = beat_out(load_word, mode, cfg_lsb_first);
                    tx_sr_d = shift_out(load_word, mode, cfg_lsb_first);
                end else begin
                    miso_d  = '0;
                    tx_sr_d = load_word;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // A back-to-back LOAD that never sees a leading edge is just the
                // master deselecting after the last frame, not an abort.
                if (cs_s) begin
                    abort_d = started_q;
                    oe_d    = '0;
                    miso_d  = '0;
                    state_d = IDLE;
                end else begin
                    if (lead) started_d = 1'b1;
                    if (do_shift) begin
                        miso_d  = beat_out(tx_sr_q, mode, cfg_lsb_first);
                        tx_sr_d = shift_out(tx_sr_q, mode, cfg_lsb_first);
                    end
                    if (do_sample) begin
                        rx_sr_d = shift_in(rx_sr_q, mosi_s, mode, cfg_lsb_first);
                        cnt_d   = cnt_inc;
                        if (cnt_inc == beats_n) state_d = DONE;
                    end
                end
            end
            DONE: begin
                rx_data_d  = rx_sr_q;
                rx_valid_d = 1'b1;
                if (cs_s) begin
                    oe_d    = '0;
                    miso_d  = '0;
                    state_d = IDLE;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            cnt_q      <= '0;
            miso_q     <= '0;
            oe_q       <= '0;
            started_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            started_q  <= started_d;
            rx_valid_q <= rx_valid_d;
            abort_q    <= abort_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_abort = abort_q;
    assign tx_ready    = (state_q == LOAD) &  tx_valid;
    assign underrun    = (state_q == LOAD) & ~tx_valid;

endmodule
